// File: rtl/imem_sync_if.sv
// Fetch / program-load bus between the PC stage, the loader and imem_sync.
// With IMEM_PARITY_EN defined the bus also carries ld_par_flip and par_err.
interface imem_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_oor;
  logic              ready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
`ifdef IMEM_PARITY_EN
  logic              ld_par_flip;
  logic              par_err;

  modport master (
    output fetch_req, pc, stall, ld_en, ld_addr, ld_data, ld_par_flip,
    input  instr, instr_valid, instr_oor, ready, ld_ack, par_err
  );
  modport slave (
    input  fetch_req, pc, stall, ld_en, ld_addr, ld_data, ld_par_flip,
    output instr, instr_valid, instr_oor, ready, ld_ack, par_err
  );
`else
  modport master (
    output fetch_req, pc, stall, ld_en, ld_addr, ld_data,
    input  instr, instr_valid, instr_oor, ready, ld_ack
  );
  modport slave (
    input  fetch_req, pc, stall, ld_en, ld_addr, ld_data,
    output instr, instr_valid, instr_oor, ready, ld_ack
  );
`endif
endinterface

// File: rtl/imem_sync.sv
// Runtime-loadable instruction RAM with a registered one-cycle fetch and stall hold.
// After reset it clears every word to NOOP; IMEM_PARITY_EN adds a stored parity bit per word.
module imem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 64
) (
  input logic        clk,
  input logic        rst_n,
  imem_sync_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;
  // One extra bit so DEPTH == 2**ADDR_W is representable for the range compare.
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic              valid;
    logic              oor;
    logic              perr;
  } rsp_t;

  logic [WORD_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  rsp_t              rsp_q, rsp_d;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] ld_word;
  logic [WORD_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;
  logic              rd_perr;
  logic              pc_in, ld_in, accept;

  assign pc_in   = ({1'b0, bus.pc} < DEPTH_L);
  assign ld_in   = ({1'b0, bus.ld_addr} < DEPTH_L);
  assign accept  = bus.fetch_req & ready_q & ~bus.stall;
  // Index is only consumed when pc_in holds, so no aliasing for non-power-of-two DEPTH.
  assign rd_word = mem[bus.pc[IDX_W-1:0]];
  assign rd_data = rd_word[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
  assign ld_word = {(^bus.ld_data) ^ bus.ld_par_flip, bus.ld_data};
  assign rd_perr = rd_word[DATA_W] ^ (^rd_data);
`else
  assign ld_word = bus.ld_data;
  assign rd_perr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    rsp_d   = rsp_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_word = '0;
    case (state_q)
      CLEAR: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
          ptr_d   = '0;
        end
      end
      default: begin
        ack_d = bus.ld_en & ready_q;
        // Out-of-range loads are acknowledged but never written.
        if (bus.ld_en && ready_q && ld_in) begin
          wr_en   = 1'b1;
          wr_idx  = bus.ld_addr[IDX_W-1:0];
          wr_word = ld_word;
        end
        if (ready_q && !bus.stall) begin
          rsp_d.valid = accept;
          rsp_d.oor   = accept & ~pc_in;
          rsp_d.perr  = accept & pc_in & rd_perr;
          if (accept) rsp_d.instr = pc_in ? rd_data : '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
    end
  end

  // Array is not reset; CLEAR overwrites it. The read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_word;
  end

  assign bus.instr       = rsp_q.instr;
  assign bus.instr_valid = rsp_q.valid;
  assign bus.instr_oor   = rsp_q.oor;
  assign bus.ready       = ready_q;
  assign bus.ld_ack      = ack_q;
`ifdef IMEM_PARITY_EN
  assign bus.par_err     = rsp_q.perr;
`endif
endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: clear sequencing, vector table with scoreboard,
// stall hold, out-of-range handling, read-before-write and mid-run reset.
module tb_imem_sync;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imem_sync_if #(.DATA_W(32), .ADDR_W(16)) bus ();
  imem_sync #(.DATA_W(32), .ADDR_W(16), .DEPTH(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        fr;
    logic [15:0] pc;
    logic        st;
    logic        le;
    logic [15:0] la;
    logic [31:0] ld;
    logic        pf;
    logic [31:0] e_instr;
    logic        e_v;
    logic        e_oor;
    logic        e_ack;
    logic        e_par;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(logic fr, logic [15:0] pc, logic st, logic le, logic [15:0] la,
                              logic [31:0] ld, logic pf, logic [31:0] ei, logic ev,
                              logic eo, logic ea, logic ep);
    vec_t v;
    v.fr = fr; v.pc = pc; v.st = st; v.le = le; v.la = la; v.ld = ld; v.pf = pf;
    v.e_instr = ei; v.e_v = ev; v.e_oor = eo; v.e_ack = ea; v.e_par = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic fr, logic [15:0] pc, logic st, logic le, logic [15:0] la,
                       logic [31:0] ld, logic pf);
    bus.fetch_req = fr; bus.pc = pc; bus.stall = st;
    bus.ld_en = le; bus.ld_addr = la; bus.ld_data = ld;
`ifdef IMEM_PARITY_EN
    bus.ld_par_flip = pf;
`else
    if (pf) ; // flip has no port without parity
`endif
  endtask

  task automatic run_vec(vec_t v, string tag);
    vec_t e;
    drive(v.fr, v.pc, v.st, v.le, v.la, v.ld, v.pf);
    sb.push_back(v);
    tick();
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, bus.instr, e.e_instr);
      chk({tag, "_valid"}, {31'd0, bus.instr_valid}, {31'd0, e.e_v});
      chk({tag, "_oor"},   {31'd0, bus.instr_oor},   {31'd0, e.e_oor});
      chk({tag, "_ack"},   {31'd0, bus.ld_ack},      {31'd0, e.e_ack});
      chk({tag, "_ready"}, {31'd0, bus.ready},       32'd1);
`ifdef IMEM_PARITY_EN
      chk({tag, "_par"},   {31'd0, bus.par_err},     {31'd0, e.e_par});
`endif
    end
  endtask

  // Release reset and walk the 64-cycle clear while requests are held high.
  task automatic do_clear(string tag);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      drive(1'b1, 16'd5, 1'b0, cyc <= 10, 16'd2, 32'hDEAD_BEEF, 1'b0);
      tick();
      chk({tag, "_ready"}, {31'd0, bus.ready}, {31'd0, cyc == 64});
      chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
      chk({tag, "_ack"},   {31'd0, bus.ld_ack}, 32'd0);
    end
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    chk({tag, "_oor"},   {31'd0, bus.instr_oor}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd0);
    chk({tag, "_ack"},   {31'd0, bus.ld_ack}, 32'd0);
`ifdef IMEM_PARITY_EN
    chk({tag, "_par"},   {31'd0, bus.par_err}, 32'd0);
`endif
  endtask

  initial begin
    //               fr  pc      st  le  la      ld            pf  instr         v  oor ack par
    vecs.push_back(mk(1, 16'd5,  0,  0,  16'd0,  32'h0,        0,  32'h0,        1, 0,  0,  0));
    vecs.push_back(mk(0, 16'd0,  0,  1,  16'd1,  32'hC8210005, 0,  32'h0,        0, 0,  1,  0));
    vecs.push_back(mk(1, 16'd1,  0,  0,  16'd0,  32'h0,        0,  32'hC8210005, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd64, 0,  0,  16'd0,  32'h0,        0,  32'h0,        1, 1,  0,  0));
    vecs.push_back(mk(0, 16'd0,  0,  1,  16'd70, 32'hFFFFFFFF, 0,  32'h0,        0, 0,  1,  0));
    vecs.push_back(mk(1, 16'd6,  0,  0,  16'd0,  32'h0,        0,  32'h0,        1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd2,  0,  0,  16'd0,  32'h0,        0,  32'h0,        1, 0,  0,  0));
    vecs.push_back(mk(0, 16'd0,  0,  1,  16'd3,  32'h40E10000, 0,  32'h0,        0, 0,  1,  0));
    vecs.push_back(mk(1, 16'd3,  0,  1,  16'd3,  32'h12345678, 0,  32'h40E10000, 1, 0,  1,  0));
    vecs.push_back(mk(1, 16'd3,  0,  0,  16'd0,  32'h0,        0,  32'h12345678, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd1,  0,  1,  16'd63, 32'hA5A5A5A5, 0,  32'hC8210005, 1, 0,  1,  0));
    vecs.push_back(mk(1, 16'd63, 0,  1,  16'd2,  32'h0000BEEF, 0,  32'hA5A5A5A5, 1, 0,  1,  0));
    vecs.push_back(mk(1, 16'd2,  0,  1,  16'd0,  32'h11111111, 0,  32'h0000BEEF, 1, 0,  1,  0));
    vecs.push_back(mk(1, 16'd0,  0,  0,  16'd0,  32'h0,        0,  32'h11111111, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'hFFFF,0, 0,  16'd0,  32'h0,        0,  32'h0,        1, 1,  0,  0));
    vecs.push_back(mk(1, 16'd1,  0,  0,  16'd0,  32'h0,        0,  32'hC8210005, 1, 0,  0,  0));
    vecs.push_back(mk(0, 16'd1,  0,  0,  16'd0,  32'h0,        0,  32'hC8210005, 0, 0,  0,  0));
    vecs.push_back(mk(1, 16'd1,  0,  0,  16'd0,  32'h0,        0,  32'hC8210005, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd2,  1,  0,  16'd0,  32'h0,        0,  32'hC8210005, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd2,  1,  0,  16'd0,  32'h0,        0,  32'hC8210005, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd2,  1,  0,  16'd0,  32'h0,        0,  32'hC8210005, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd2,  0,  0,  16'd0,  32'h0,        0,  32'h0000BEEF, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd1,  1,  1,  16'd5,  32'h5555AAAA, 0,  32'h0000BEEF, 1, 0,  1,  0));
    vecs.push_back(mk(1, 16'd5,  0,  0,  16'd0,  32'h0,        0,  32'h5555AAAA, 1, 0,  0,  0));
    vecs.push_back(mk(1, 16'd100,0,  0,  16'd0,  32'h0,        0,  32'h0,        1, 1,  0,  0));
    vecs.push_back(mk(1, 16'd1,  1,  0,  16'd0,  32'h0,        0,  32'h0,        1, 1,  0,  0));
    vecs.push_back(mk(0, 16'd1,  1,  0,  16'd0,  32'h0,        0,  32'h0,        1, 1,  0,  0));
    vecs.push_back(mk(0, 16'd1,  0,  0,  16'd0,  32'h0,        0,  32'h0,        0, 0,  0,  0));
    vecs.push_back(mk(1, 16'd1,  0,  0,  16'd0,  32'h0,        0,  32'hC8210005, 1, 0,  0,  0));
`ifdef IMEM_PARITY_EN
    vecs.push_back(mk(0, 16'd0,  0,  1,  16'd9,  32'h00000007, 1,  32'hC8210005, 0, 0,  1,  0));
    vecs.push_back(mk(1, 16'd9,  0,  0,  16'd0,  32'h0,        0,  32'h00000007, 1, 0,  0,  1));
    vecs.push_back(mk(1, 16'd9,  1,  1,  16'd9,  32'h00000007, 0,  32'h00000007, 1, 0,  1,  1));
    vecs.push_back(mk(1, 16'd9,  0,  0,  16'd0,  32'h0,        0,  32'h00000007, 1, 0,  0,  0));
`endif

    rst_n = 1'b0;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
    repeat (3) tick();
    chk_reset_state("rst");

    do_clear("clr");
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset mid-run: outputs drop without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("mrst");
    tick();
    tick();
    do_clear("mclr");
    run_vec(mk(1, 16'd1, 0, 0, 16'd0, 32'h0, 0, 32'h0, 1, 0, 0, 0), "post1");
    run_vec(mk(1, 16'd3, 0, 0, 16'd0, 32'h0, 0, 32'h0, 1, 0, 0, 0), "post3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Parametrised, clocked successor to the CPU's hardcoded instruction memory.
- Holds DEPTH instruction words in a RAM array:
  - loaded at runtime through a write port;
  - read through a registered, one-cycle fetch handshake with stall support.
- Sits between the PC register and the decode stage, so the pipeline no longer needs `define-selected programs.
- After reset, an internal sequencer clears every word to NOOP (all zeros) before any fetch is accepted.

Parameters:
- DATA_W, 32: instruction width in bits.
- ADDR_W, 16: PC / load address width in bits.
- DEPTH, 64: number of stored words, 2..2**ADDR_W; need not be a power of two.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request for pc this cycle.
- pc  in  ADDR_W  word address of the instruction.
- stall  in  1  pipeline stall; freezes output registers.
- instr  out  DATA_W  fetched instruction (registered).
- instr_valid  out  1  instr holds a completed fetch.
- instr_oor  out  1  completed fetch had pc >= DEPTH.
- ready  out  1  memory is out of clear and accepts requests.
- ld_en  in  1  write-strobe for program load.
- ld_addr  in  ADDR_W  load word address.
- ld_data  in  DATA_W  load word.
- ld_ack  out  1  registered; pulses the cycle after an accepted load.

Behaviour:
- Reset (rst_n low, asynchronous):
  - instr=0, instr_valid=0, instr_oor=0, ready=0, ld_ack=0;
  - FSM enters CLEAR with clear pointer 0.
  - Array contents are not reset directly; they are overwritten by CLEAR.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Writes 0 to array[ptr] each cycle; ptr increments.
  - When ptr==DEPTH-1 is written, moves to RUN the next cycle. CLEAR lasts exactly DEPTH cycles after rst_n deasserts.
  - ready=0. fetch_req and ld_en are ignored: no ld_ack, no instr_valid.
- RUN:
  - ready=1 (registered).
  - There is no exit except reset.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from ptr 0.
- Fetch accept: accept = fetch_req & ready & ~stall.
  - Latency is 1 cycle. On the edge after accept: instr=array[pc], instr_valid=1, instr_oor=0.
  - If pc >= DEPTH: instr=0 (NOOP), instr_valid=1, instr_oor=1. No wrap-around and no aliasing.
  - On a cycle with ready & ~stall & ~fetch_req: instr_valid=0 next edge and instr_oor=0. instr keeps its last value.
- Stall: while stall=1, instr, instr_valid and instr_oor hold unchanged and fetch_req is not accepted. Loads still proceed during stall.
- Load:
  - Accepted when ld_en & ready. ld_ack=1 the following cycle, otherwise 0.
  - ld_addr >= DEPTH: write is dropped, ld_ack still pulses.
- Same-cycle load and fetch to the same address: read-before-write. instr returns the old word; the new word is visible to the next fetch.
- Back-to-back fetches sustain 1 instruction per cycle. Back-to-back loads sustain 1 word per cycle.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from ld_data on load; CLEAR writes parity 0.
  - Extra input ld_par_flip (1 bit) inverts the stored parity bit on that load, for error injection.
  - Extra output par_err (1 bit, reset 0) follows the same timing and stall-hold rules as instr_valid.
  - par_err=1 when an in-range fetched word's stored parity mismatches the recomputed parity. It is 0 for out-of-range fetches.
- Undefined: no parity storage, no ld_par_flip or par_err ports. Behaviour is otherwise identical.

Test Plan:
- Reset clear:
  - Stimulus: deassert rst_n, DEPTH=64, fetch_req=1 from cycle 0.
  - Response: ready rises on exactly cycle 64 with no instr_valid before it; fetch pc=5 afterwards returns instr=0x00000000, instr_valid=1.
- Load then fetch:
  - Stimulus: ld_en with ld_addr=1, ld_data=0xC8210005; then fetch pc=1.
  - Response: ld_ack pulses once; next cycle instr=0xC8210005, instr_oor=0.
- Out of range:
  - Stimulus: fetch pc=64; load ld_addr=70, ld_data=0xFFFFFFFF; then fetch pc=6.
  - Response: pc=64 fetch gives instr=0 with instr_oor=1; the pc=70 load still gets ld_ack; pc=6 returns 0 (no aliasing).
- Read-before-write:
  - Stimulus: address 3 holds 0x40E10000; in the same cycle, load 3 with 0x12345678 and fetch pc=3; then fetch pc=3 again.
  - Response: first fetch gives 0x40E10000; second gives 0x12345678.
- Stall and reset:
  - Stimulus: fetch pc=1, then stall for 3 cycles while pc=2 is requested.
  - Response: instr stays 0xC8210005 and valid for all 3 cycles; after stall drops, pc=2 data appears 1 cycle later.
  - Stimulus: assert rst_n low mid-run.
  - Response: instr_valid/ready drop immediately, then a full 64-cycle CLEAR runs.
- Parity (IMEM_PARITY_EN):
  - Stimulus: load 0x00000007 at address 9 with ld_par_flip=1, then fetch pc=9.
  - Response: par_err=1.
  - Stimulus: reload the same word with ld_par_flip=0, then fetch pc=9.
  - Response: par_err=0.
